// File: rtl/plab4_net_router_sched_if.sv
// Handshake bundle between a router's input heads, its crossbar select and the
// downstream channels; the scheduler drives the slave side.
interface plab4_net_router_sched_if #(
    parameter int p_dest_nbits = 3
);
    logic [2:0]                in_val;
    logic [3*p_dest_nbits-1:0] in_dest;
    logic [2:0]                in_dom;
    logic [2:0]                in_rdy;
    logic [2:0]                out_val;
    logic [2:0]                out_rdy;
    logic [5:0]                out_sel;
    logic                      cur_dom;

    modport master (
        output in_val, in_dest, in_dom, out_rdy,
        input  in_rdy, out_val, out_sel, cur_dom
    );

    modport slave (
        input  in_val, in_dest, in_dom, out_rdy,
        output in_rdy, out_val, out_sel, cur_dom
    );
endinterface

// File: rtl/plab4_net_router_sched.sv
// Ring-router switch scheduler: shortest-path route per input head, per-output
// round-robin arbitration, and time-sliced security domains with a guard cycle.
module plab4_net_router_sched #(
    parameter int  p_router_id   = 0,
    parameter int  p_num_routers = 8,
    parameter int  p_epoch_len   = 4,
    localparam int c_dest_nbits  = $clog2(p_num_routers)
) (
    input logic                     clk,
    input logic                     reset,
    plab4_net_router_sched_if.slave bus
);
    localparam int                       c_epoch_nbits = $clog2(p_epoch_len);
    localparam logic [c_epoch_nbits-1:0] c_epoch_last  = c_epoch_nbits'(p_epoch_len - 1);
    localparam logic [c_dest_nbits-1:0]  c_id          = c_dest_nbits'(p_router_id);

    localparam logic [1:0] c_route_prev = 2'd0;
    localparam logic [1:0] c_route_next = 2'd1;
    localparam logic [1:0] c_route_term = 2'd2;

    // (base + step) mod 3 for base, step in 0..2
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Routing: hop counts wrap naturally in c_dest_nbits arithmetic
    // ------------------------------------------------------------------
    logic [1:0] route [3];

    for (genvar i = 0; i < 3; i++) begin : g_route
        logic [c_dest_nbits-1:0] dest;
        logic [c_dest_nbits-1:0] hop_next;
        logic [c_dest_nbits-1:0] hop_prev;

        assign dest     = bus.in_dest[i*c_dest_nbits +: c_dest_nbits];
        assign hop_next = dest - c_id;
        assign hop_prev = c_id - dest;
        assign route[i] = (dest == c_id)          ? c_route_term :
                          (hop_next < hop_prev)   ? c_route_next :
                                                    c_route_prev;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     run_q, run_d;
    logic [c_epoch_nbits-1:0] epoch_q, epoch_d;
    logic                     cur_dom_q, cur_dom_d;
    logic [1:0]               ptr_q [3];
    logic [1:0]               ptr_d [3];

    // run_q holds the epoch at slot 0 until the first edge after reset and
    // blocks grants before it, so the slot timing never depends on traffic.
    logic open_c;
    assign open_c = run_q && (epoch_q != c_epoch_last);

    // ------------------------------------------------------------------
    // Eligibility and round-robin arbitration
    // ------------------------------------------------------------------
    logic [2:0] elig    [3];
    logic [2:0] win_val;
    logic [1:0] win_idx [3];

    // NOTE: every output of a combinational block is given a value on every
    // path (here by a default at the top), otherwise a latch is inferred.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            elig[o] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                elig[o][i] = open_c && bus.in_val[i] && (route[i] == 2'(o))
                             && (bus.in_dom[i] == cur_dom_q);
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            win_val[o] = 1'b0;
            win_idx[o] = 2'd0;
            for (int k = 0; k < 3; k++) begin
                if (!win_val[o] && elig[o][rr_idx(ptr_q[o], 2'(k))]) begin
                    win_val[o] = 1'b1;
                    win_idx[o] = rr_idx(ptr_q[o], 2'(k));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: out_val is independent of out_rdy; in_rdy is the dequeue
    // ------------------------------------------------------------------
    logic [2:0] in_rdy_c;
    logic [5:0] out_sel_c;

    always_comb begin
        in_rdy_c  = 3'b000;
        out_sel_c = 6'b000000;
        for (int o = 0; o < 3; o++) begin
            if (win_val[o]) begin
                out_sel_c[2*o +: 2] = win_idx[o];
                if (bus.out_rdy[o]) begin
                    in_rdy_c[win_idx[o]] = 1'b1;
                end
            end
        end
    end

    assign bus.in_rdy  = in_rdy_c;
    assign bus.out_val = win_val;
    assign bus.out_sel = out_sel_c;
    assign bus.cur_dom = cur_dom_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        run_d     = 1'b1;
        epoch_d   = epoch_q;
        cur_dom_d = cur_dom_q;
        if (run_q) begin
            if (epoch_q == c_epoch_last) begin
                epoch_d   = '0;
                cur_dom_d = ~cur_dom_q;
            end else begin
                epoch_d = epoch_q + 1'b1;
            end
        end
        for (int o = 0; o < 3; o++) begin
            ptr_d[o] = (win_val[o] && bus.out_rdy[o]) ? rr_idx(win_idx[o], 2'd1) : ptr_q[o];
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            epoch_q   <= '0;
            cur_dom_q <= 1'b0;
            for (int o = 0; o < 3; o++) begin
                ptr_q[o] <= 2'd0;
            end
        end else begin
            run_q     <= run_d;
            epoch_q   <= epoch_d;
            cur_dom_q <= cur_dom_d;
            for (int o = 0; o < 3; o++) begin
                ptr_q[o] <= ptr_d[o];
            end
        end
    end
endmodule

// File: tb/tb_plab4_net_router_sched.sv
// Directed and random stimulus for plab4_net_router_sched, checked against a
// cycle-count based model of routing, domain slots and round-robin fairness.
module tb_plab4_net_router_sched;
    localparam int         ID  = 2;
    localparam int         NR  = 8;
    localparam int         EL  = 4;
    localparam int         DB  = 3;
    localparam logic [2:0] DID = 3'(ID);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    plab4_net_router_sched_if #(.p_dest_nbits(DB)) bus ();

    plab4_net_router_sched #(
        .p_router_id  (ID),
        .p_num_routers(NR),
        .p_epoch_len  (EL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: cycles since the first edge after reset, and RR pointers.
    int m_cyc;
    int m_ptr [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    // Shortest way round the ring; equal distance goes to the previous neighbour.
    function automatic int route_of(input int dest);
        int hn;
        int hp;
        if (dest == ID) return 2;
        hn = (dest - ID + NR) % NR;
        hp = (ID - dest + NR) % NR;
        return (hn < hp) ? 1 : 0;
    endfunction

    task automatic drive(input logic [2:0] v, input logic [8:0] d,
                         input logic [2:0] dm, input logic [2:0] rdy);
        bus.in_val  = v;
        bus.in_dest = d;
        bus.in_dom  = dm;
        bus.out_rdy = rdy;
    endtask

    // Called 1ns after a rising edge; drives one cycle, checks it, advances.
    task automatic do_cycle(input string tag, input logic [2:0] v, input logic [8:0] d,
                            input logic [2:0] dm, input logic [2:0] rdy);
        logic [2:0] e_val;
        logic [2:0] e_rdy;
        logic [5:0] e_sel;
        int         dom;
        bit         guard;
        int         win;
        int         idx;
        drive(v, d, dm, rdy);
        dom   = (m_cyc / EL) % 2;
        guard = (m_cyc % EL) == EL - 1;
        e_val = 3'b000;
        e_rdy = 3'b000;
        e_sel = 6'b000000;
        for (int o = 0; o < 3; o++) begin
            win = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr[o] + k) % 3;
                if (win < 0 && !guard && v[idx] && route_of(int'(d[3*idx +: 3])) == o
                    && int'(dm[idx]) == dom) begin
                    win = idx;
                end
            end
            if (win >= 0) begin
                e_val[o]        = 1'b1;
                e_sel[2*o +: 2] = 2'(win);
                if (rdy[o]) begin
                    e_rdy[win] = 1'b1;
                    m_ptr[o]   = (win + 1) % 3;
                end
            end
        end
        #2;
        chk({tag, "/out_val"}, 8'(bus.out_val), 8'(e_val));
        chk({tag, "/out_sel"}, 8'(bus.out_sel), 8'(e_sel));
        chk({tag, "/in_rdy"},  8'(bus.in_rdy),  8'(e_rdy));
        chk({tag, "/cur_dom"}, 8'(bus.cur_dom), 8'(dom));
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle with eligible heads present, checks outputs are
    // forced low at once and across an edge, then releases between edges.
    task automatic apply_reset(input string tag);
        drive(3'b111, {DID, DID, DID}, 3'b000, 3'b111);
        #1 reset = 1'b0;
        #1;
        chk({tag, "/rst_val"}, 8'(bus.out_val), 8'd0);
        chk({tag, "/rst_rdy"}, 8'(bus.in_rdy),  8'd0);
        chk({tag, "/rst_sel"}, 8'(bus.out_sel), 8'd0);
        chk({tag, "/rst_dom"}, 8'(bus.cur_dom), 8'd0);
        @(posedge clk);
        #1;
        chk({tag, "/rst_val_edge"}, 8'(bus.out_val), 8'd0);
        chk({tag, "/rst_rdy_edge"}, 8'(bus.in_rdy),  8'd0);
        @(negedge clk);
        reset = 1'b1;
        m_cyc = 0;
        m_ptr = '{0, 0, 0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(3'b000, 9'd0, 3'b000, 3'b000);
        m_cyc = 0;
        m_ptr = '{0, 0, 0};

        // Idle traffic: domain slots still run, nothing is granted.
        apply_reset("por");
        for (int c = 0; c < 8; c++) do_cycle("idle", 3'b000, 9'd0, 3'b000, 3'b111);

        // Terminal injection delivered locally in the same cycle.
        apply_reset("term_rst");
        do_cycle("term", 3'b100, {DID, 3'd0, 3'd0}, 3'b000, 3'b111);

        // in0 -> next neighbour, in2 at the tie distance -> prev neighbour.
        apply_reset("tie_rst");
        do_cycle("tie", 3'b101, {3'd6, 3'd0, 3'd3}, 3'b000, 3'b111);

        // Two contenders for the terminal port across both domain slots.
        apply_reset("rr_rst");
        for (int c = 0; c < 8; c++) do_cycle("rr", 3'b101, {DID, 3'd0, DID}, 3'b000, 3'b111);

        // Domain-1 head waits for its slot.
        apply_reset("dom_rst");
        for (int c = 0; c < 8; c++) do_cycle("dom1", 3'b010, {3'd0, DID, 3'd0}, 3'b010, 3'b111);

        // Stalled output keeps its pointer; reset mid-epoch wipes everything.
        apply_reset("stall_rst");
        do_cycle("stall", 3'b010, {3'd0, DID, 3'd0}, 3'b000, 3'b011);
        do_cycle("after_stall", 3'b111, {DID, DID, DID}, 3'b000, 3'b111);
        apply_reset("mid_rst");
        for (int c = 0; c < 5; c++) do_cycle("post_rst", 3'b100, {DID, 3'd0, 3'd0}, 3'b000, 3'b111);

        // Random traffic, with one reset dropped into the middle.
        for (int n = 0; n < 300; n++) begin
            if (n == 153) apply_reset("rand_rst");
            do_cycle("rand", 3'($urandom_range(0, 7)), 9'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
